// File: rtl/vga_bus_ctrl.sv
// VGA timing generator with a background colour and one solid rectangle, behind a single-cycle bus port.
// Colour and rectangle registers are staged by the bus and copied to the active set at each frame start.
module vga_bus_ctrl #(
    parameter int unsigned HActive = 640,
    parameter int unsigned HFront  = 16,
    parameter int unsigned HSync   = 96,
    parameter int unsigned HBack   = 48,
    parameter int unsigned VActive = 480,
    parameter int unsigned VFront  = 10,
    parameter int unsigned VSync   = 2,
    parameter int unsigned VBack   = 33,
    parameter int unsigned PixDiv  = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    output logic [11:0] vga_rgb_o,
    output logic        vga_hsync_o,
    output logic        vga_vsync_o,
    output logic        frame_irq_o
);

    localparam int unsigned HTotal = HActive + HFront + HSync + HBack;
    localparam int unsigned VTotal = VActive + VFront + VSync + VBack;
    localparam int unsigned DivW   = (PixDiv > 1) ? $clog2(PixDiv) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(PixDiv - 1);
    localparam logic [9:0] HLast      = 10'(HTotal - 1);
    localparam logic [9:0] VLast      = 10'(VTotal - 1);
    localparam logic [9:0] HAct       = 10'(HActive);
    localparam logic [9:0] VAct       = 10'(VActive);
    localparam logic [9:0] VActLast   = 10'(VActive - 1);
    localparam logic [9:0] HSyncStart = 10'(HActive + HFront);
    localparam logic [9:0] HSyncEnd   = 10'(HActive + HFront + HSync);
    localparam logic [9:0] VSyncStart = 10'(VActive + VFront);
    localparam logic [9:0] VSyncEnd   = 10'(VActive + VFront + VSync);

    typedef enum logic [9:0] {
        REG_CTRL   = 10'h000,
        REG_BG     = 10'h001,
        REG_FG     = 10'h002,
        REG_RECT_X = 10'h003,
        REG_RECT_Y = 10'h004,
        REG_STATUS = 10'h005,
        REG_POS    = 10'h006
    } reg_off_e;

    logic            ctrl_en_q, ctrl_en_d, ctrl_irq_en_q, ctrl_irq_en_d;
    logic [11:0]     bg_q, bg_d, fg_q, fg_d, act_bg_q, act_bg_d, act_fg_q, act_fg_d;
    logic [9:0]      x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [9:0]      act_x0_q, act_x0_d, act_x1_q, act_x1_d, act_y0_q, act_y0_d, act_y1_q, act_y1_d;
    logic            pend_q, pend_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [DivW-1:0] div_q, div_d;
    logic [9:0]      hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic            rvalid_q, rvalid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [11:0]     rgb_q, rgb_d;
    logic            hsync_q, hsync_d, vsync_q, vsync_d, irq_q, irq_d;

    logic [9:0] off;
    logic       wr, pix_en, frame_start, vblank, active, in_rect;
    logic       unused_bits;

    assign off         = device_addr_i[11:2];
    assign wr          = device_req_i && device_we_i;
    assign pix_en      = (div_q == DivLast);
    assign frame_start = ctrl_en_q && pix_en && (hcnt_q == HLast) && (vcnt_q == VActLast);
    assign vblank      = (vcnt_q >= VAct);
    assign active      = (hcnt_q < HAct) && (vcnt_q < VAct);
    // An inverted range (x0>x1 or y0>y1) can never satisfy both bounds, so nothing is drawn.
    assign in_rect     = (hcnt_q >= act_x0_q) && (hcnt_q <= act_x1_q) &&
                         (vcnt_q >= act_y0_q) && (vcnt_q <= act_y1_q);
    assign unused_bits = ^{device_addr_i[31:12], device_addr_i[1:0],
                           device_wdata_i[31:26], device_wdata_i[15:12]};

    always_comb begin
        ctrl_en_d     = ctrl_en_q;
        ctrl_irq_en_d = ctrl_irq_en_q;
        bg_d          = bg_q;
        fg_d          = fg_q;
        x0_d          = x0_q;
        x1_d          = x1_q;
        y0_d          = y0_q;
        y1_d          = y1_q;
        act_bg_d      = act_bg_q;
        act_fg_d      = act_fg_q;
        act_x0_d      = act_x0_q;
        act_x1_d      = act_x1_q;
        act_y0_d      = act_y0_q;
        act_y1_d      = act_y1_q;
        pend_d        = pend_q;
        frame_cnt_d   = frame_cnt_q;
        div_d         = div_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;

        if (wr) begin
            case (off)
                REG_CTRL: if (device_be_i[0]) {ctrl_irq_en_d, ctrl_en_d} = device_wdata_i[1:0];
                REG_BG: begin
                    if (device_be_i[0]) bg_d[7:0]  = device_wdata_i[7:0];
                    if (device_be_i[1]) bg_d[11:8] = device_wdata_i[11:8];
                end
                REG_FG: begin
                    if (device_be_i[0]) fg_d[7:0]  = device_wdata_i[7:0];
                    if (device_be_i[1]) fg_d[11:8] = device_wdata_i[11:8];
                end
                REG_RECT_X: begin
                    if (device_be_i[0]) x0_d[7:0] = device_wdata_i[7:0];
                    if (device_be_i[1]) x0_d[9:8] = device_wdata_i[9:8];
                    if (device_be_i[2]) x1_d[7:0] = device_wdata_i[23:16];
                    if (device_be_i[3]) x1_d[9:8] = device_wdata_i[25:24];
                end
                REG_RECT_Y: begin
                    if (device_be_i[0]) y0_d[7:0] = device_wdata_i[7:0];
                    if (device_be_i[1]) y0_d[9:8] = device_wdata_i[9:8];
                    if (device_be_i[2]) y1_d[7:0] = device_wdata_i[23:16];
                    if (device_be_i[3]) y1_d[9:8] = device_wdata_i[25:24];
                end
                REG_STATUS: if (device_be_i[0] && device_wdata_i[1]) pend_d = 1'b0;
                default: ;
            endcase
        end

        // Shadow copy reads the _q staged values, so a coincident write lands next frame.
        if (frame_start) begin
            pend_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            act_bg_d    = bg_q;
            act_fg_d    = fg_q;
            act_x0_d    = x0_q;
            act_x1_d    = x1_q;
            act_y0_d    = y0_q;
            act_y1_d    = y1_q;
        end

        if (!ctrl_en_q) begin
            div_d  = '0;
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (pix_en) begin
            div_d = '0;
            if (hcnt_q == HLast) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end

        rvalid_d = device_req_i;
        rdata_d  = '0;
        if (device_req_i && !device_we_i) begin
            case (off)
                REG_CTRL:   rdata_d = {30'd0, ctrl_irq_en_q, ctrl_en_q};
                REG_BG:     rdata_d = {20'd0, bg_q};
                REG_FG:     rdata_d = {20'd0, fg_q};
                REG_RECT_X: rdata_d = {6'd0, x1_q, 6'd0, x0_q};
                REG_RECT_Y: rdata_d = {6'd0, y1_q, 6'd0, y0_q};
                REG_STATUS: rdata_d = {frame_cnt_q, 14'd0, pend_q, vblank};
                REG_POS:    rdata_d = {6'd0, vcnt_q, 6'd0, hcnt_q};
                default:    rdata_d = '0;
            endcase
        end

        rgb_d   = (ctrl_en_q && active) ? (in_rect ? act_fg_q : act_bg_q) : '0;
        hsync_d = !(ctrl_en_q && (hcnt_q >= HSyncStart) && (hcnt_q < HSyncEnd));
        vsync_d = !(ctrl_en_q && (vcnt_q >= VSyncStart) && (vcnt_q < VSyncEnd));
        irq_d   = pend_d & ctrl_irq_en_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_en_q     <= 1'b0;
            ctrl_irq_en_q <= 1'b0;
            bg_q          <= '0;
            fg_q          <= '1;
            x0_q          <= '0;
            x1_q          <= '0;
            y0_q          <= '0;
            y1_q          <= '0;
            act_bg_q      <= '0;
            act_fg_q      <= '1;
            act_x0_q      <= '0;
            act_x1_q      <= '0;
            act_y0_q      <= '0;
            act_y1_q      <= '0;
            pend_q        <= 1'b0;
            frame_cnt_q   <= '0;
            div_q         <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            irq_q         <= 1'b0;
        end else begin
            ctrl_en_q     <= ctrl_en_d;
            ctrl_irq_en_q <= ctrl_irq_en_d;
            bg_q          <= bg_d;
            fg_q          <= fg_d;
            x0_q          <= x0_d;
            x1_q          <= x1_d;
            y0_q          <= y0_d;
            y1_q          <= y1_d;
            act_bg_q      <= act_bg_d;
            act_fg_q      <= act_fg_d;
            act_x0_q      <= act_x0_d;
            act_x1_q      <= act_x1_d;
            act_y0_q      <= act_y0_d;
            act_y1_q      <= act_y1_d;
            pend_q        <= pend_d;
            frame_cnt_q   <= frame_cnt_d;
            div_q         <= div_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            irq_q         <= irq_d;
        end
    end

    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;
    assign vga_rgb_o       = rgb_q;
    assign vga_hsync_o     = hsync_q;
    assign vga_vsync_o     = vsync_q;
    assign frame_irq_o     = irq_q;

endmodule

// File: tb/tb_vga_bus_ctrl.sv
// Directed bench for vga_bus_ctrl with a 14x7-pixel raster (28-clk lines, 196-clk frames).
module tb_vga_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        rvalid;
    logic [31:0] rdata;
    logic [11:0] rgb;
    logic        hsync, vsync, irq;

    int unsigned n_assert = 0;
    int unsigned n_fail = 0;
    int          cyc = 0;
    int          base = 0;
    logic [31:0] d;

    localparam logic [31:0] A_CTRL = 32'h00, A_BG = 32'h04, A_FG = 32'h08, A_RX = 32'h0C,
                            A_RY = 32'h10, A_STAT = 32'h14, A_POS = 32'h18, A_BAD = 32'h40;

    vga_bus_ctrl #(
        .HActive(8), .HFront(2), .HSync(2), .HBack(2),
        .VActive(4), .VFront(1), .VSync(1), .VBack(1),
        .PixDiv(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .device_req_i(req), .device_addr_i(addr), .device_we_i(we),
        .device_be_i(be), .device_wdata_i(wdata),
        .device_rvalid_o(rvalid), .device_rdata_o(rdata),
        .vga_rgb_o(rgb), .vga_hsync_o(hsync), .vga_vsync_o(vsync),
        .frame_irq_o(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $error("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left just after a falling edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b);
        req = 1'b1; we = 1'b1; addr = a; wdata = wd; be = b;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        chk("wr_rvalid", 32'(rvalid), 32'd1);
        chk("wr_rdata", rdata, 32'd0);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] rd);
        req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
        @(negedge clk);
        req = 1'b0;
        chk("rd_rvalid", 32'(rvalid), 32'd1);
        rd = rdata;
    endtask

    // k counts samples since enable; sample k shows pixel k/2 of a raster starting at (0,0).
    function automatic void model(input int k, output logic [11:0] e_rgb, output logic e_hs,
                                  output logic e_vs);
        int p, l, f, h, v, x0, x1, y0, y1;
        logic [11:0] bgc, fgc;
        p = k / 2; l = p % 98; f = p / 98; h = l % 14; v = l / 14;
        if (f == 0) begin
            bgc = 12'h000; fgc = 12'hFFF; x0 = 0; x1 = 0; y0 = 0; y1 = 0;
        end else begin
            bgc = 12'h00F; fgc = 12'hF00; x0 = (f >= 2) ? 5 : 2; x1 = 3; y0 = 1; y1 = 1;
        end
        if (h < 8 && v < 4)
            e_rgb = (h >= x0 && h <= x1 && v >= y0 && v <= y1) ? fgc : bgc;
        else
            e_rgb = 12'h000;
        e_hs = !(h >= 10 && h < 12);
        e_vs = (v != 5);
    endfunction

    task automatic check_pix(input logic e_irq);
        logic [11:0] e_rgb;
        logic e_hs, e_vs;
        model(cyc - base, e_rgb, e_hs, e_vs);
        chk($sformatf("rgb@%0d", cyc - base), 32'(rgb), 32'(e_rgb));
        chk($sformatf("hsync@%0d", cyc - base), 32'(hsync), 32'(e_hs));
        chk($sformatf("vsync@%0d", cyc - base), 32'(vsync), 32'(e_vs));
        chk($sformatf("irq@%0d", cyc - base), 32'(irq), 32'(e_irq));
    endtask

    task automatic wait_k(input int k);
        while (cyc - base < k) @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rgb"}, 32'(rgb), 32'd0);
        chk({tag, "_hsync"}, 32'(hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(vsync), 32'd1);
        chk({tag, "_irq"}, 32'(irq), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("rst0");
        chk("rst0_rvalid", 32'(rvalid), 32'd0);
        chk("rst0_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        bus_read(A_CTRL, d); chk("rst_ctrl", d, 32'h0);
        bus_read(A_BG, d);   chk("rst_bg", d, 32'h0);
        bus_read(A_FG, d);   chk("rst_fg", d, 32'h0000_0FFF);
        bus_read(A_RX, d);   chk("rst_rectx", d, 32'h0);
        bus_read(A_RY, d);   chk("rst_recty", d, 32'h0);
        bus_read(A_STAT, d); chk("rst_status", d, 32'h0);
        bus_read(A_POS, d);  chk("rst_pos", d, 32'h0);

        bus_write(A_BG, 32'h0000_0AF0, 4'b0001);
        @(negedge clk); chk("rvalid_one_cycle_wr", 32'(rvalid), 32'd0);
        bus_read(A_BG, d); chk("bg_be0", d, 32'h0000_00F0);
        @(negedge clk); chk("rvalid_one_cycle_rd", 32'(rvalid), 32'd0);
        bus_write(A_BG, 32'h0000_0300, 4'b0010);
        bus_read(A_BG, d); chk("bg_be1", d, 32'h0000_03F0);
        bus_write(A_RX, 32'h0003_00FF, 4'b0100);
        bus_read(A_RX, d); chk("rectx_be2", d, 32'h0003_0000);
        bus_read(A_BAD, d); chk("unmapped_rd", d, 32'h0);
        bus_write(A_BAD, 32'hFFFF_FFFF, 4'hF);
        bus_read(A_BG, d); chk("unmapped_wr", d, 32'h0000_03F0);

        bus_write(A_BG, 32'h0000_000F, 4'hF);
        bus_write(A_FG, 32'h0000_0F00, 4'hF);
        bus_write(A_RX, 32'h0003_0002, 4'hF);
        bus_write(A_RY, 32'h0001_0001, 4'hF);
        base = cyc + 2;
        bus_write(A_CTRL, 32'h3, 4'hF);
        @(negedge clk);

        // Frame 0 shows reset shadow values; frame start at sample 111 raises the IRQ.
        while (cyc - base < 200) begin
            check_pix(cyc - base >= 111);
            @(negedge clk);
        end
        bus_read(A_STAT, d); chk("status_f1", d, 32'h0001_0002);
        bus_write(A_RX, 32'h0003_0005, 4'hF);
        while (cyc - base < 520) begin
            check_pix(1'b1);
            @(negedge clk);
        end

        bus_write(A_STAT, 32'h2, 4'h1);
        chk("w1c_irq", 32'(irq), 32'd0);
        bus_read(A_STAT, d); chk("status_w1c", d, 32'h0003_0001);

        wait_k(698);
        bus_write(A_STAT, 32'h2, 4'h1);
        chk("w1c_vs_set_irq", 32'(irq), 32'd1);
        bus_read(A_STAT, d); chk("status_set_wins", d, 32'h0004_0003);

        wait_k(720);
        check_pix(1'b1);
        bus_write(A_CTRL, 32'h0, 4'hF);
        @(negedge clk);
        chk_idle("dis");
        bus_read(A_POS, d);  chk("dis_pos", d, 32'h0);
        bus_read(A_STAT, d); chk("dis_status", d, 32'h0004_0002);
        repeat (300) @(negedge clk);
        chk_idle("dis_late");
        bus_read(A_STAT, d); chk("dis_frozen", d, 32'h0004_0002);

        bus_write(A_CTRL, 32'h3, 4'hF);
        repeat (40) @(negedge clk);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        req = 1'b1; we = 1'b0; addr = A_BG;
        @(posedge clk); #1;
        chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_idle("rst1");
        chk("rst1_rvalid", 32'(rvalid), 32'd0);
        chk("rst1_rdata", rdata, 32'd0);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(A_POS, d);  chk("rst1_pos", d, 32'h0);
        bus_read(A_CTRL, d); chk("rst1_ctrl", d, 32'h0);
        bus_read(A_FG, d);   chk("rst1_fg", d, 32'h0000_0FFF);
        bus_read(A_STAT, d); chk("rst1_status", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_bus_ctrl.md
Name: vga_bus_ctrl

Overview:
Memory-mapped VGA display controller. It is a bus device downstream of the system bus, occupying one 4 KiB device window, and replaces the ad-hoc GPIO-driven VGA path. It generates VGA timing and renders a background colour plus one solid foreground rectangle, using double-buffered registers that update only at vblank. It raises a per-frame interrupt toward the core's fast-IRQ input.

Parameters:
HActive, 640, visible pixels per line
HFront, 16, horizontal front porch (pixels)
HSync, 96, hsync pulse width (pixels)
HBack, 48, horizontal back porch (pixels)
VActive, 480, visible lines per frame
VFront, 10, vertical front porch (lines)
VSync, 2, vsync pulse width (lines)
VBack, 33, vertical back porch (lines)
PixDiv, 2, system clocks per pixel (50 MHz to 25 MHz); must be >= 1

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
device_req_i  in  1  bus request (single-cycle)
device_addr_i  in  32  byte address; only [11:2] decoded
device_we_i  in  1  write enable
device_be_i  in  4  byte enables
device_wdata_i  in  32  write data
device_rvalid_o  out  1  response valid
device_rdata_o  out  32  read data
vga_rgb_o  out  12  {R[3:0],G[3:0],B[3:0]}
vga_hsync_o  out  1  active-low hsync
vga_vsync_o  out  1  active-low vsync
frame_irq_o  out  1  level interrupt

Behaviour:
- One clock domain (clk_i), asynchronous active-low reset rst_ni. All state is reset.
- Output reset values: rvalid=0, rdata=0, rgb=0, hsync=1, vsync=1, irq=0.
- Bus handshake: every req is accepted. rvalid asserts exactly 1 cycle after req, for both reads and writes. rdata is registered and valid with rvalid; rdata=0 on writes and on unmapped offsets.
- Register writes honour device_be_i per byte lane. Unmapped writes are ignored.
- Register map (offset: field, reset value):
  0x00 CTRL: [0] EN=0, [1] IRQ_EN=0.
  0x04 BG: [11:0] staged background colour = 0.
  0x08 FG: [11:0] staged foreground colour = 0xFFF.
  0x0C RECT_X: [9:0] x0=0, [25:16] x1=0.
  0x10 RECT_Y: [9:0] y0=0, [25:16] y1=0.
  0x14 STATUS: [0] VBLANK (RO), [1] IRQ_PEND (write 1 to clear), [31:16] FRAME_CNT (RO, 16-bit, wraps 0xFFFF to 0).
  0x18 POS (RO): [9:0] hcnt, [25:16] vcnt.
- Pixel enable: a divider counts 0..PixDiv-1; pix_en is high when it equals PixDiv-1. With PixDiv=1, pix_en is constant 1.
- Timing: on pix_en, hcnt increments. hcnt wraps to 0 at HTOTAL-1 = HActive+HFront+HSync+HBack-1. vcnt increments on hcnt wrap and wraps at VTOTAL-1.
- Sync windows: hsync_n=0 when HActive+HFront <= hcnt < HActive+HFront+HSync. vsync uses the same rule with the V parameters.
- Active region: hcnt<HActive && vcnt<VActive. VBLANK = (vcnt >= VActive).
- Colour selection in the active region: pixel = FG if act_x0<=hcnt<=act_x1 and act_y0<=vcnt<=act_y1 (inclusive), else BG. If x0>x1 or y0>y1, no rectangle is drawn. Outside the active region rgb=0.
- Output latency: rgb/hsync/vsync are registered, 1 clk after the counter values that produce them.
- Shadowing: staged BG/FG/RECT copy to the active set on the frame-start event. A write in the same cycle as the event copies the old staged value; the new value takes effect next frame.
- Frame-start event: pix_en && hcnt==HTOTAL-1 && vcnt==VActive-1 (the last active pixel tick, so the new vcnt enters vblank). On this event: FRAME_CNT+1, IRQ_PEND set, shadow copy.
- frame_irq_o = IRQ_PEND & IRQ_EN, registered.
- A W1C write on the same cycle as the set event: set wins.
- EN=0: divider, hcnt and vcnt held at 0. rgb=0, syncs=1, no events. Registers remain accessible.
- EN 0 to 1: counting starts at hcnt=vcnt=0 on the next pix_en.
- Reset mid-frame: everything returns to reset values immediately (asynchronous).

Test Plan:
- Reset: assert rst_ni low mid-frame -> rgb=0, hsync=vsync=1, irq=0, rvalid=0, POS reads 0 after release.
- Bus: write BG=0x0F0 with be=4'b0001 -> readback 0x0F0 (other lanes unchanged). Read offset 0x40 -> rdata=0. Check rvalid exactly 1 cycle after each req.
- Timing (HActive=8,HFront=2,HSync=2,HBack=2,VActive=4,VFront=1,VSync=1,VBack=1,PixDiv=2): EN=1 -> hsync low for 4 clks per 28-clk line, vsync low for 28 clks per 196-clk frame.
- Rectangle (small params): BG=0x00F, FG=0xF00, x0=2, x1=3, y0=1, y1=1 -> only pixels (2,1),(3,1) are 0xF00, rest of active area 0x00F. Then write x0=5 mid-frame -> change visible only after the next frame-start event.
- IRQ: IRQ_EN=1 -> frame_irq_o rises 1 clk after frame-start and FRAME_CNT=1. Write STATUS=0x2 -> irq drops. W1C coincident with frame-start -> IRQ_PEND stays 1.
- Disable: clear EN mid-line -> next cycle counters 0, rgb=0, syncs high, FRAME_CNT frozen.
